// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: one request per cycle to a 1-cycle-latency memory, 2-entry response FIFO toward decode.
// Latency: accept in N, push at the end of N+1, head visible in N+2; req_ready drops when FIFO plus in-flight would exceed 2.
module imem_fetch_responder #(
    parameter int          IDX_W     = 10,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_pc,
    input  logic             flush,
    output logic             mem_rd_en,
    output logic [IDX_W-1:0] mem_addr,
    input  logic [31:0]      mem_rdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_instr,
    output logic [31:0]      rsp_pc,
    output logic             rsp_misaligned
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        mis;
    } fetch_ent_t;

    fetch_ent_t  fifo_q [2];
    logic [1:0]  count;
    logic        wr_ptr;
    logic        rd_ptr;

    logic        inflight;
    logic [31:0] if_pc;
    logic        if_mis;
    logic        if_kill;

    logic        pop;
    logic        push;
    logic        accept;
    logic [2:0]  occupancy;
    fetch_ent_t  push_ent;
    fetch_ent_t  head;

    assign rsp_valid = (count != 2'd0);
    assign pop       = rsp_valid && rsp_ready;

    // Slots already committed: buffered entries plus the word returning now, minus what decode takes this cycle.
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign req_ready = !reset && !flush && (occupancy < 3'd2);
    assign accept    = req_valid && req_ready;

    assign mem_rd_en = accept;
    assign mem_addr  = req_pc[IDX_W+1:2];

    assign push      = inflight && !if_kill && !flush;

    always_comb begin
        push_ent       = '0;
        push_ent.instr = if_mis ? NOP_INSTR : mem_rdata;
        push_ent.pc    = if_pc;
        push_ent.mis   = if_mis;
    end

    assign head           = fifo_q[rd_ptr];
    assign rsp_instr      = head.instr;
    assign rsp_pc         = head.pc;
    assign rsp_misaligned = head.mis;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
            if_pc    <= '0;
            if_mis   <= 1'b0;
            if_kill  <= 1'b0;
        end else begin
            inflight <= accept;
            if_kill  <= flush;
            if (accept) begin
                if_pc  <= req_pc;
                if_mis <= (req_pc[1:0] != 2'b00);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage resets to a NOP so the head fields read a harmless instruction before the first fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                fifo_q[i].instr <= NOP_INSTR;
                fifo_q[i].pc    <= '0;
                fifo_q[i].mis   <= 1'b0;
            end
        end else if (push) begin
            fifo_q[wr_ptr] <= push_ent;
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_imem_fetch_responder;

    localparam int          IDX_W = 10;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_pc;
    logic             flush;
    logic             mem_rd_en;
    logic [IDX_W-1:0] mem_addr;
    logic [31:0]      mem_rdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_instr;
    logic [31:0]      rsp_pc;
    logic             rsp_misaligned;

    imem_fetch_responder #(.IDX_W(IDX_W), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_pc         (req_pc),
        .flush          (flush),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_instr      (rsp_instr),
        .rsp_pc         (rsp_pc),
        .rsp_misaligned (rsp_misaligned)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [2**IDX_W];

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        mis;
    } ent_t;

    ent_t q[$];
    ent_t pend;
    bit   pend_vld;

    int vectors = 0;
    int errs    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Compares outputs with the model at mid-cycle, then advances the model across the coming edge.
    task automatic model_step();
        bit   pop_m;
        bit   rdy_m;
        bit   acc;
        int   occ;
        ent_t e;
        pop_m = (q.size() != 0) && rsp_ready;
        occ   = q.size() + int'(pend_vld) - int'(pop_m);
        rdy_m = !flush && (occ < 2);
        acc   = req_valid && rdy_m;
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, q.size() != 0});
        if (q.size() != 0) begin
            chk("rsp_instr", rsp_instr, q[0].instr);
            chk("rsp_pc", rsp_pc, q[0].pc);
            chk("rsp_mis", {31'b0, rsp_misaligned}, {31'b0, q[0].mis});
        end
        chk("req_ready", {31'b0, req_ready}, {31'b0, rdy_m});
        chk("mem_rd_en", {31'b0, mem_rd_en}, {31'b0, acc});
        if (acc) chk("mem_addr", {22'b0, mem_addr}, {22'b0, req_pc[IDX_W+1:2]});

        if (flush) begin
            q.delete();
        end else begin
            if (pop_m) void'(q.pop_front());
            if (pend_vld) q.push_back(pend);
        end
        pend_vld = acc;
        if (acc) begin
            e.pc    = req_pc;
            e.mis   = (req_pc[1:0] != 2'b00);
            e.instr = e.mis ? NOP : mem[req_pc[IDX_W+1:2]];
            pend    = e;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input bit rr, input bit fl);
        req_valid = v;
        req_pc    = pc;
        rsp_ready = rr;
        flush     = fl;
    endtask

    task automatic drain();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (4) tick();
    endtask

    initial begin
        for (int k = 0; k < 2**IDX_W; k++) mem[k] = 32'h1000_0000 + k;
        mem_rdata = '0;
        pend_vld  = 1'b0;
        reset     = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_mem_rd_en", {31'b0, mem_rd_en}, 32'd0);
        chk("rst_rsp_pc", rsp_pc, 32'd0);
        chk("rst_rsp_instr", rsp_instr, NOP);
        @(posedge clk);
        #1;

        // Streaming: four back-to-back fetches, one response per cycle from cycle 2.
        for (int i = 0; i < 6; i++) begin
            drive(i < 4, 32'(i * 4), 1'b1, 1'b0);
            @(negedge clk);
            chk("stream_ready", {31'b0, req_ready}, 32'd1);
            if (i >= 2) begin
                chk("stream_pc", rsp_pc, 32'((i - 2) * 4));
                chk("stream_instr", rsp_instr, 32'h1000_0000 + 32'(i - 2));
            end
            model_step();
            @(posedge clk);
            #1;
        end
        drain();

        // Backpressure: third request stalls until decode frees a slot.
        drive(1'b1, 32'h20, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h24, 1'b0, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h28, 1'b0, 1'b0);
            @(negedge clk);
            chk("bp_stall_ready", {31'b0, req_ready}, 32'd0);
            if (i > 0) chk("bp_head_pc", rsp_pc, 32'h20);
            model_step();
            @(posedge clk);
            #1;
        end
        drive(1'b1, 32'h28, 1'b1, 1'b0); tick();
        drain();

        // Misaligned request followed by an aligned one.
        drive(1'b1, 32'h102, 1'b1, 1'b0); tick();
        drive(1'b1, 32'h104, 1'b1, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("mis_instr", rsp_instr, NOP);
        chk("mis_flag", {31'b0, rsp_misaligned}, 32'd1);
        chk("mis_pc", rsp_pc, 32'h102);
        model_step();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("aligned_instr", rsp_instr, 32'h1000_0041);
        chk("aligned_flag", {31'b0, rsp_misaligned}, 32'd0);
        model_step();
        @(posedge clk);
        #1;
        drain();

        // Flush with one buffered entry and one fetch returning in the flush cycle.
        drive(1'b1, 32'h40, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h44, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h48, 1'b0, 1'b1); tick();
        drive(1'b1, 32'h80, 1'b1, 1'b0);
        @(negedge clk);
        chk("flush_empty", {31'b0, rsp_valid}, 32'd0);
        model_step();
        @(posedge clk);
        #1;
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
        @(negedge clk);
        chk("post_flush_pc", rsp_pc, 32'h80);
        model_step();
        @(posedge clk);
        #1;
        drain();

        // Asynchronous reset pulse between edges with a full FIFO.
        drive(1'b1, 32'h200, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h204, 1'b0, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0); tick();
        #2 reset = 1'b1;
        #1 chk("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        #3 reset = 1'b0;
        q.delete();
        pend_vld = 1'b0;
        @(posedge clk);
        #1;
        drain();

        // Randomized traffic, including wrapping high PC bits and occasional flushes.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc;
            pc = $urandom;
            if ($urandom_range(3) != 0) pc[1:0] = 2'b00;
            drive($urandom_range(9) < 7, pc, $urandom_range(9) < 6, $urandom_range(15) == 0);
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
